vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. Samples the active-low Hsync/Vsync and the 4-bit color outputs of a VGA source, measures line and frame periods, locks after a run of consistent frames, and reconstructs pixel coordinates and pixel data. It sits in loopback and self-check paths, so the team can verify the display path on-chip and in simulation without a monitor.

---
 rtl/vga_sync_decoder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_sync_decoder                                             |
// | Description : Receive-side VGA timing decoder. Synchronises Hsync/Vsync    |
// |               and vgaRed, measures line and frame periods, locks after     |
// |               LOCK_FRAMES consecutive good frames and reconstructs pixel   |
// |               coordinates and data while locked.                           |
// | Ports       : clk, rst (async, active low)                                 |
// |               Hsync, Vsync (active low), vgaRed[3:0]       -- inputs       |
// |               locked, px_valid, px_x, px_y, px_data,                       |
// |               frame_start, h_period, v_period, sync_err    -- outputs      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_sync_decoder #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 801,
  parameter int H_SYNC      = 95,
  parameter int H_BP        = 49,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 526,
  parameter int V_SYNC      = 1,
  parameter int V_BP        = 34,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic [3:0]  vgaRed,
  output logic        locked,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [3:0]  px_data,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [10:0] v_period,
  output logic        sync_err
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [DIV_W-1:0]  c_div_last    = DIV_W'(CLK_DIV - 1);
  localparam logic [GOOD_W-1:0] c_lock_frames = GOOD_W'(LOCK_FRAMES);
  localparam logic [10:0] c_cnt_max = 11'd2047;
  localparam logic [10:0] c_h_total = 11'(H_TOTAL);
  localparam logic [10:0] c_v_total = 11'(V_TOTAL);
  localparam logic [10:0] c_h_sync  = 11'(H_SYNC);
  localparam logic [10:0] c_v_sync  = 11'(V_SYNC);
  localparam logic [10:0] c_timeout = 11'(2 * H_TOTAL);
  localparam logic [10:0] c_h_start = 11'(H_SYNC + H_BP);
  localparam logic [10:0] c_h_end   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] c_v_start = 11'(V_SYNC + V_BP);
  localparam logic [10:0] c_v_end   = 11'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Input synchronisers; sync lines idle high so reset looks like "no pulse".
  logic       hs_meta_q, hs_sync_q, vs_meta_q, vs_sync_q;
  logic [3:0] red_meta_q, red_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_meta_q  <= 1'b1;
      hs_sync_q  <= 1'b1;
      vs_meta_q  <= 1'b1;
      vs_sync_q  <= 1'b1;
      red_meta_q <= '0;
      red_sync_q <= '0;
    end else begin
      hs_meta_q  <= Hsync;
      hs_sync_q  <= hs_meta_q;
      vs_meta_q  <= Vsync;
      vs_sync_q  <= vs_meta_q;
      red_meta_q <= vgaRed;
      red_sync_q <= red_meta_q;
    end
  end

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic                hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [10:0]         h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0]         h_period_q, h_period_d, v_period_q, v_period_d;
  logic [10:0]         hs_width_q, hs_width_d, vs_width_q, vs_width_d;
  logic                h_armed_q, h_armed_d, frame_bad_q, frame_bad_d;
  logic                locked_q, locked_d, px_valid_q, px_valid_d;
  logic [9:0]          px_x_q, px_x_d, px_y_q, px_y_d;
  logic [3:0]          px_data_q, px_data_d;
  logic                frame_start_q, frame_start_d, sync_err_q, sync_err_d;

  logic        tick, h_fall, h_rise, v_fall, v_rise;
  logic        line_bad, frame_good, timeout;
  logic [10:0] h_cnt_inc, v_cnt_inc, v_line;

  always_comb begin
    tick   = (div_q == c_div_last);
    h_fall = tick &  hs_prev_q & ~hs_sync_q;
    h_rise = tick & ~hs_prev_q &  hs_sync_q;
    v_fall = tick &  vs_prev_q & ~vs_sync_q;
    v_rise = tick & ~vs_prev_q &  vs_sync_q;

    h_cnt_inc = (h_cnt_q == c_cnt_max) ? h_cnt_q : h_cnt_q + 11'd1;
    v_cnt_inc = (v_cnt_q == c_cnt_max) ? v_cnt_q : v_cnt_q + 11'd1;
    // Line count after closing a line on this tick, so a coincident
    // Vsync edge sees the line that just ended.
    v_line    = h_fall ? v_cnt_inc : v_cnt_q;

    div_d         = tick ? '0 : div_q + 1'b1;
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_period_d    = h_period_q;
    v_period_d    = v_period_q;
    hs_width_d    = hs_width_q;
    vs_width_d    = vs_width_q;
    h_armed_d     = h_armed_q;
    frame_bad_d   = frame_bad_q;
    px_x_d        = px_x_q;
    px_y_d        = px_y_q;
    px_data_d     = px_data_q;
    px_valid_d    = 1'b0;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    line_bad      = 1'b0;
    frame_good    = 1'b0;
    timeout       = 1'b0;

    if (tick) begin
      hs_prev_d = hs_sync_q;
      vs_prev_d = vs_sync_q;

      // Position counters hold the position of the current tick: the
      // Hsync edge tick is column 0, the Vsync edge line is row 0.
      if (h_fall) begin
        // The first edge after reset/SEARCH has no valid history to judge.
        line_bad    = h_armed_q && ((h_cnt_inc != c_h_total) || (hs_width_q != c_h_sync));
        h_period_d  = h_cnt_inc;
        h_cnt_d     = '0;
        h_armed_d   = 1'b1;
        frame_bad_d = frame_bad_q | line_bad;
      end else begin
        h_cnt_d = h_cnt_inc;
        timeout = (h_cnt_inc == c_timeout);
      end
      v_cnt_d = v_line;

      if (h_rise) hs_width_d = h_cnt_d;
      if (v_rise) vs_width_d = v_line;

      if (v_fall) begin
        frame_good    = !frame_bad_d && (v_line == c_v_total) && (vs_width_q == c_v_sync);
        v_period_d    = v_line;
        v_cnt_d       = '0;
        frame_bad_d   = 1'b0;
        frame_start_d = 1'b1;
      end

      case (state_q)
        ST_SEARCH: begin
          if (v_fall) begin
            state_d    = ST_TRACK;
            good_cnt_d = '0;
          end
        end
        ST_TRACK: begin
          if (v_fall) begin
            if (frame_good) begin
              good_cnt_d = good_cnt_q + 1'b1;
              if (good_cnt_q + 1'b1 == c_lock_frames) state_d = ST_LOCKED;
            end else begin
              good_cnt_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (v_fall && !frame_good) begin
            state_d    = ST_TRACK;
            good_cnt_d = '0;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase

      // Loss of Hsync overrides any frame decision on the same tick.
      if (timeout) begin
        state_d    = ST_SEARCH;
        good_cnt_d = '0;
        h_armed_d  = 1'b0;
        sync_err_d = (state_q == ST_LOCKED);
      end

      if ((state_d == ST_LOCKED) &&
          (h_cnt_d >= c_h_start) && (h_cnt_d < c_h_end) &&
          (v_cnt_d >= c_v_start) && (v_cnt_d < c_v_end)) begin
        px_valid_d = 1'b1;
        px_x_d     = 10'(h_cnt_d - c_h_start);
        px_y_d     = 10'(v_cnt_d - c_v_start);
        px_data_d  = red_sync_q;
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_SEARCH;
      div_q         <= '0;
      good_cnt_q    <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_period_q    <= '0;
      v_period_q    <= '0;
      hs_width_q    <= '0;
      vs_width_q    <= '0;
      h_armed_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      locked_q      <= 1'b0;
      px_valid_q    <= 1'b0;
      px_x_q        <= '0;
      px_y_q        <= '0;
      px_data_q     <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      good_cnt_q    <= good_cnt_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_period_q    <= h_period_d;
      v_period_q    <= v_period_d;
      hs_width_q    <= hs_width_d;
      vs_width_q    <= vs_width_d;
      h_armed_q     <= h_armed_d;
      frame_bad_q   <= frame_bad_d;
      locked_q      <= locked_d;
      px_valid_q    <= px_valid_d;
      px_x_q        <= px_x_d;
      px_y_q        <= px_y_d;
      px_data_q     <= px_data_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign locked      = locked_q;
  assign px_valid    = px_valid_q;
  assign px_x        = px_x_q;
  assign px_y        = px_y_q;
  assign px_data     = px_data_q;
  assign frame_start = frame_start_q;
  assign h_period    = h_period_q;
  assign v_period    = v_period_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_sync_decoder                                          |
// | Description : Self-checking bench for vga_sync_decoder using a reduced     |
// |               raster. A frame table drives lock/bad-line/bad-width cases;  |
// |               hand sequences cover Hsync timeout and mid-frame reset.      |
// |               Active pixels are queued when driven and popped on px_valid. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vga_sync_decoder;

  localparam int CLK_DIV     = 2;
  localparam int H_TOTAL     = 20;
  localparam int H_SYNC      = 3;
  localparam int H_BP        = 2;
  localparam int H_ACTIVE    = 8;
  localparam int V_TOTAL     = 12;
  localparam int V_SYNC      = 1;
  localparam int V_BP        = 2;
  localparam int V_ACTIVE    = 6;
  localparam int LOCK_FRAMES = 2;
  localparam int HS0         = H_SYNC + H_BP;
  localparam int VS0         = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Hsync = 1'b1;
  logic        Vsync = 1'b1;
  logic [3:0]  vgaRed = 4'h0;
  logic        locked, px_valid, frame_start, sync_err;
  logic [9:0]  px_x, px_y;
  logic [3:0]  px_data;
  logic [10:0] h_period, v_period;

  vga_sync_decoder #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .H_ACTIVE(H_ACTIVE), .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .V_ACTIVE(V_ACTIVE), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .Hsync(Hsync), .Vsync(Vsync), .vgaRed(vgaRed),
    .locked(locked), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_data(px_data), .frame_start(frame_start), .h_period(h_period),
    .v_period(v_period), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int d; } px_t;

  typedef struct {
    int bad_row;     // line shortened by one tick, -1 for none
    int hsw;         // Hsync low width of every line in this frame
    bit exp_locked;  // expected right after this frame's Vsync edge
    int exp_err;     // sync_err strobes from closing the previous frame
    int exp_hp;      // -1: not checked
    int exp_vp;      // -1: not checked
  } vec_t;

  px_t  exp_q[$];
  px_t  mon_e;
  vec_t vecs[17];
  int   errors = 0, checks = 0;
  int   fs_seen = 0, err_seen = 0, px_seen = 0, px_pushed = 0;
  int   fs_mark = 0, err_mark = 0;

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Pixel scoreboard and strobe counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (sync_err)    err_seen++;
    if (px_valid) begin
      px_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL px_extra: got x=%0d y=%0d d=%0d expected no pixel", px_x, px_y, px_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(px_x) != mon_e.x || int'(px_y) != mon_e.y || int'(px_data) != mon_e.d) begin
          errors++;
          $display("FAIL px: got x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d",
                   px_x, px_y, px_data, mon_e.x, mon_e.y, mon_e.d);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_locked"},      int'(locked), 0);
    check_val({tag, "_px_valid"},    int'(px_valid), 0);
    check_val({tag, "_px_x"},        int'(px_x), 0);
    check_val({tag, "_px_y"},        int'(px_y), 0);
    check_val({tag, "_px_data"},     int'(px_data), 0);
    check_val({tag, "_frame_start"}, int'(frame_start), 0);
    check_val({tag, "_sync_err"},    int'(sync_err), 0);
    check_val({tag, "_h_period"},    int'(h_period), 0);
    check_val({tag, "_v_period"},    int'(v_period), 0);
  endtask

  task automatic check_frame(input string tag, input bit exp_locked, input int exp_err,
                             input int exp_hp, input int exp_vp);
    check_val({tag, "_locked"}, int'(locked), int'(exp_locked));
    check_val({tag, "_frame_start"}, fs_seen - fs_mark, 1);
    check_val({tag, "_sync_err"}, err_seen - err_mark, exp_err);
    if (exp_hp >= 0) check_val({tag, "_h_period"}, int'(h_period), exp_hp);
    if (exp_vp >= 0) check_val({tag, "_v_period"}, int'(v_period), exp_vp);
    fs_mark  = fs_seen;
    err_mark = err_seen;
  endtask

  task automatic drive_px(input logic hs, input logic vs, input logic [3:0] red);
    Hsync  = hs;
    Vsync  = vs;
    vgaRed = red;
    repeat (CLK_DIV) @(negedge clk);
  endtask

  // One frame. Checks the closing of the previous frame a few pixels into
  // row 0; optionally pulses reset in the front porch of rst_row.
  task automatic drive_frame(input string tag, input int bad_row, input int hsw,
                             input bit exp_locked, input int exp_err,
                             input int exp_hp, input int exp_vp, input int rst_row);
    int         len;
    bit         push, act;
    logic [3:0] red;
    px_t        e;
    push = exp_locked;
    for (int row = 0; row < V_TOTAL; row++) begin
      len = (row == bad_row) ? H_TOTAL - 1 : H_TOTAL;
      for (int p = 0; p < len; p++) begin
        if (row == 0 && p == 4) begin
          #1;
          check_frame(tag, exp_locked, exp_err, exp_hp, exp_vp);
        end
        act = (p >= HS0) && (p < HS0 + H_ACTIVE) && (row >= VS0) && (row < VS0 + V_ACTIVE);
        red = act ? 4'(p - HS0) : 4'hA;
        if (act && push) begin
          e.x = p - HS0; e.y = row - VS0; e.d = (p - HS0) % 16;
          exp_q.push_back(e);
          px_pushed++;
        end
        if (row == rst_row && p == 16) begin
          rst = 1'b0;
          #1;
          check_reset_outputs({tag, "_midrst"});
          check_val({tag, "_midrst_px_drained"}, exp_q.size(), 0);
          push = 1'b0;
          drive_px((p >= hsw), (row >= V_SYNC), red);
          rst = 1'b1;
        end else begin
          drive_px((p >= hsw), (row >= V_SYNC), red);
        end
      end
    end
  endtask

  initial begin
    //           bad  hsw lock err  hp  vp
    vecs[0]  = '{-1, 3, 1'b0, 0, -1, -1};  // SEARCH -> TRACK
    vecs[1]  = '{-1, 3, 1'b0, 0, 20, 12};  // good 1
    vecs[2]  = '{-1, 3, 1'b1, 0, 20, 12};  // good 2 -> LOCKED on 3rd edge
    vecs[3]  = '{-1, 3, 1'b1, 0, 20, 12};
    vecs[4]  = '{11, 3, 1'b1, 0, 20, 12};  // last line one tick short
    vecs[5]  = '{-1, 3, 1'b0, 1, 19, 12};  // bad frame: err, unlock
    vecs[6]  = '{-1, 3, 1'b0, 0, 20, 12};
    vecs[7]  = '{-1, 3, 1'b1, 0, 20, 12};  // relock after 2 good frames
    vecs[8]  = '{-1, 4, 1'b1, 0, 20, 12};  // wrong Hsync width begins
    vecs[9]  = '{-1, 4, 1'b0, 1, 20, 12};
    vecs[10] = '{-1, 4, 1'b0, 0, 20, 12};
    vecs[11] = '{-1, 4, 1'b0, 0, 20, 12};
    vecs[12] = '{-1, 4, 1'b0, 0, 20, 12};
    vecs[13] = '{-1, 4, 1'b0, 0, 20, 12};
    vecs[14] = '{-1, 3, 1'b0, 0, 20, 12};  // closes last wide frame
    vecs[15] = '{-1, 3, 1'b0, 0, 20, 12};
    vecs[16] = '{-1, 3, 1'b1, 0, 20, 12};

    #2 rst = 1'b0;
    #1 check_reset_outputs("por");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 17; i++)
      drive_frame($sformatf("v%0d", i), vecs[i].bad_row, vecs[i].hsw, vecs[i].exp_locked,
                  vecs[i].exp_err, vecs[i].exp_hp, vecs[i].exp_vp, -1);

    // Hsync stops: last edge was row 11, 20 + 30 ticks without an edge.
    repeat (30) drive_px(1'b1, 1'b1, 4'hA);
    #1;
    check_val("timeout_locked", int'(locked), 0);
    check_val("timeout_sync_err", err_seen - err_mark, 1);
    check_val("timeout_frame_start", fs_seen - fs_mark, 0);
    check_val("timeout_px_valid", int'(px_valid), 0);
    err_mark = err_seen;
    fs_mark  = fs_seen;

    // Reacquire from SEARCH, then reset in the middle of a locked frame.
    drive_frame("toA", -1, 3, 1'b0, 0, 50, 12, -1);
    drive_frame("toB", -1, 3, 1'b0, 0, 20, 12, -1);
    drive_frame("toC", -1, 3, 1'b1, 0, 20, 12, 5);
    drive_frame("rsD", -1, 3, 1'b0, 0, 20, 7, -1);
    drive_frame("rsE", -1, 3, 1'b0, 0, 20, 12, -1);
    drive_frame("rsF", -1, 3, 1'b1, 0, 20, 12, -1);

    repeat (8) drive_px(1'b1, 1'b1, 4'hA);
    check_val("px_queue_empty", exp_q.size(), 0);
    check_val("px_count", px_seen, px_pushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
